ex_stage_md: RTL
================

Name: ex_stage_md

Overview:
Next-generation MIPS execute stage. It keeps the single-cycle ALU path: operand forwarding, shamt-based shifts, immediate select, branch resolve, jr target and destination-register select. It adds an iterative multiply/divide unit with architectural HI/LO registers and a pipeline interlock. The block sits between the ID/EX and EX/MEM pipeline registers; its stall output freezes IF/ID/EX upstream.

Parameters:
XLEN, 32, datapath width; must equal the width of the instantiated alu.
MD_STEP, 1, quotient/product bits resolved per cycle; legal values 1, 2, 4; must divide XLEN.
DIV0_LO, all ones, LO value written on divide-by-zero.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  EX holds a valid instruction
rd1, rd2, imm  in  XLEN each  register operands, extended immediate
shamt  in  5  shift amount
rt, rd  in  5 each  destination candidates
alusrc, regdst  in  1 each  B-select, destination-select
alu_ctrl  in  4  ALU op; 1000 sll, 1010 srl, 1011 sra
md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
forwardA, forwardB  in  2 each  00 reg, 10 EX/MEM, 01 MEM/WB, 11 reg
exmem_aluout, memwb_wdata  in  XLEN each  forwarded values
is_branch, is_branch_ne  in  1 each  beq / bne
kill  in  1  exception/flush; aborts the MD operation
alu_result  out  XLEN  ALU result, or HI/LO for mfhi/mflo
alu_zero  out  1  ALU result is zero
branch_taken  out  1  (is_branch & zero) | (is_branch_ne & ~zero)
jump_target  out  XLEN  rd1 (jr target)
store_data  out  XLEN  forwarded B operand
writereg  out  5  regdst ? rd : rt
stall  out  1  interlock request
md_busy  out  1  MD iteration in progress
hi, lo  out  XLEN each  architectural HI/LO

Behaviour:
- Combinational path:
  - Forward muxes select per the forwardA/forwardB encoding above.
  - ALU B = {0, shamt} for sll/srl/sra; otherwise imm if alusrc, else forwarded B.
  - mfhi/mflo override alu_result with hi/lo.
- Reset (async, rst_n=0): FSM to IDLE; hi, lo, counter and work registers to 0; md_busy=0; stall=0.
- FSM states:
  - IDLE: on a posedge with valid_in & ~stall & ~kill & md_op in 1..4, latch the forwarded A/B operands and enter MUL (ops 1, 2) or DIV (ops 3, 4); counter = XLEN/MD_STEP.
  - MUL/DIV: resolve MD_STEP bits per cycle; counter decrements each cycle; at counter==1 write HI/LO and return to IDLE.
- Latency: an op accepted at edge T makes md_busy high from T; HI/LO update at edge T+XLEN/MD_STEP (32 cycles at defaults); md_busy falls with that edge.
- The issuing mult/div retires immediately; the pipeline continues.
- stall = valid_in & (md_op != 0) & md_busy. A stalled instruction is not accepted, and mthi/mtlo are not applied.
- mthi/mtlo: write forwarded A into hi/lo at the edge, only when valid_in & ~stall & ~kill.
- Arithmetic:
  - mult/multu: {HI,LO} = full 2*XLEN product.
  - Signed ops: iterate on magnitudes. Negate the product/quotient if operand signs differ; the remainder takes the dividend's sign (truncating division).
  - div/divu: LO = quotient, HI = remainder.
  - Divisor 0: HI = dividend, LO = DIV0_LO, same latency.
  - Signed overflow: div of most-negative by -1 gives LO = most-negative, HI = 0.
- Boundaries:
  - kill during MUL/DIV: return to IDLE next edge; HI/LO unchanged.
  - kill together with an accept condition: kill wins, nothing starts.
  - kill has no effect in IDLE other than blocking accept/mthi/mtlo.
  - rst_n low mid-operation: immediate abort and clear.
  - Op accepted in the same cycle that a previous op completes: impossible, because stall is still high.

Test Plan:
1. mult rd1=0xFFFFFFFD (-3), rd2=5 -> md_busy high 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; multu same operands -> hi=0x00000004, lo=0xFFFFFFF1.
2. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> hi=7, lo=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
3. mult, then mflo one cycle later -> stall=1 for 31 cycles; on release alu_result=lo; an intervening add with md_op=0 never stalls.
4. kill at cycle 10 of div -> md_busy drops next edge, hi/lo keep prior values; rst_n pulse mid-mult -> hi=lo=0, idle.
5. forwardA=10, exmem_aluout=6, forwardB=01, memwb_wdata=6, is_branch=1, alu_ctrl=sub -> alu_zero=1, branch_taken=1, store_data=6.
6. mthi with forwarded A=0x1234 while idle -> hi=0x1234 next edge; sra with shamt=4 on 0x80000000 -> 0xF8000000.

Source files
------------

// File: rtl/ex_stage_md.sv
// MIPS execute stage: single-cycle ALU path with forwarding and branch resolve,
// plus an iterative multiply/divide unit that owns HI/LO and raises a pipeline interlock.

module ex_stage_md_alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      ctrl_i,
    output logic [XLEN-1:0] y_o,
    output logic            zero_o
);
    // 0000 and, 0001 or, 0010 add, 0011 xor, 0110 sub, 0111 slt, 1001 sltu,
    // 1000 sll, 1010 srl, 1011 sra, 1100 nor; shifts move A by B[4:0]
    always_comb begin
        y_o = '0;
        case (ctrl_i)
            4'b0000: y_o = a_i & b_i;
            4'b0001: y_o = a_i | b_i;
            4'b0010: y_o = a_i + b_i;
            4'b0011: y_o = a_i ^ b_i;
            4'b0110: y_o = a_i - b_i;
            4'b0111: y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            4'b1001: y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            4'b1000: y_o = a_i << b_i[4:0];
            4'b1010: y_o = a_i >> b_i[4:0];
            4'b1011: y_o = $signed(a_i) >>> b_i[4:0];
            4'b1100: y_o = ~(a_i | b_i);
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);
endmodule

module ex_stage_md #(
    parameter int              XLEN    = 32,
    parameter int              MD_STEP = 1,
    parameter logic [XLEN-1:0] DIV0_LO = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in_i,
    input  logic [XLEN-1:0] rd1_i,
    input  logic [XLEN-1:0] rd2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      shamt_i,
    input  logic [4:0]      rt_i,
    input  logic [4:0]      rd_i,
    input  logic            alusrc_i,
    input  logic            regdst_i,
    input  logic [3:0]      alu_ctrl_i,
    input  logic [3:0]      md_op_i,
    input  logic [1:0]      forwardA_i,
    input  logic [1:0]      forwardB_i,
    input  logic [XLEN-1:0] exmem_aluout_i,
    input  logic [XLEN-1:0] memwb_wdata_i,
    input  logic            is_branch_i,
    input  logic            is_branch_ne_i,
    input  logic            kill_i,
    output logic [XLEN-1:0] alu_result_o,
    output logic            alu_zero_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] jump_target_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [4:0]      writereg_o,
    output logic            stall_o,
    output logic            md_busy_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic [1:0]      md_state_o
);
    localparam int CNT_INIT = XLEN / MD_STEP;
    localparam int CW       = $clog2(CNT_INIT + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} md_state_e;

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, wrk_q, opd_q, hi_q, lo_q;
    logic            neg_res_q, neg_rem_q, div0_q;

    logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_y;
    logic            alu_zero, is_shift;
    logic            accept, start_md, is_mul_op, is_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            md_busy, md_done;

    always_comb begin
        case (forwardA_i)
            2'b10:   fwd_a = exmem_aluout_i;
            2'b01:   fwd_a = memwb_wdata_i;
            default: fwd_a = rd1_i;
        endcase
        case (forwardB_i)
            2'b10:   fwd_b = exmem_aluout_i;
            2'b01:   fwd_b = memwb_wdata_i;
            default: fwd_b = rd2_i;
        endcase
    end

    assign is_shift = (alu_ctrl_i == 4'b1000) || (alu_ctrl_i == 4'b1010) || (alu_ctrl_i == 4'b1011);
    assign alu_b    = is_shift ? {{(XLEN-5){1'b0}}, shamt_i} : (alusrc_i ? imm_i : fwd_b);

    ex_stage_md_alu #(.XLEN(XLEN)) u_alu (
        .a_i    (fwd_a),
        .b_i    (alu_b),
        .ctrl_i (alu_ctrl_i),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    always_comb begin
        alu_result_o = alu_y;
        if (md_op_i == 4'd5) alu_result_o = hi_q;
        else if (md_op_i == 4'd6) alu_result_o = lo_q;
    end

    assign alu_zero_o     = alu_zero;
    assign branch_taken_o = (is_branch_i & alu_zero) | (is_branch_ne_i & ~alu_zero);
    assign jump_target_o  = rd1_i;
    assign store_data_o   = fwd_b;
    assign writereg_o     = regdst_i ? rd_i : rt_i;

    // Any MD-class instruction waits while the unit iterates; plain ALU ops flow through.
    assign stall_o  = valid_in_i & (md_op_i != 4'd0) & md_busy;
    assign accept   = valid_in_i & ~stall_o & ~kill_i;
    assign start_md = accept & (state_q == S_IDLE) & (md_op_i >= 4'd1) & (md_op_i <= 4'd4);

    assign is_mul_op = (md_op_i == 4'd1) || (md_op_i == 4'd2);
    assign is_signed = (md_op_i == 4'd1) || (md_op_i == 4'd3);
    assign a_neg     = is_signed & fwd_a[XLEN-1];
    assign b_neg     = is_signed & fwd_b[XLEN-1];
    assign a_mag     = a_neg ? -fwd_a : fwd_a;
    assign b_mag     = b_neg ? -fwd_b : fwd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_md) state_d = is_mul_op ? S_MUL : S_DIV;
            S_MUL, S_DIV: if (kill_i || cnt_q == CW'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        md_busy = (state_q != S_IDLE);
        md_done = md_busy & ~kill_i & (cnt_q == CW'(1));
    end

    assign md_busy_o  = md_busy;
    assign md_state_o = state_q;

    // Shift-add multiply: acc holds the running high half, wrk the multiplier/low half.
    logic [XLEN:0]   mul_h;
    logic [XLEN-1:0] mul_l;
    always_comb begin
        mul_h = {1'b0, acc_q};
        mul_l = wrk_q;
        for (int i = 0; i < MD_STEP; i++) begin
            if (mul_l[0]) mul_h = {1'b0, mul_h[XLEN-1:0]} + {1'b0, opd_q};
            mul_l = {mul_h[0], mul_l[XLEN-1:1]};
            mul_h = mul_h >> 1;
        end
    end

    // Restoring divide: acc is the partial remainder, wrk shifts dividend out and quotient in.
    logic [XLEN:0]   div_t;
    logic [XLEN-1:0] div_r, div_q;
    always_comb begin
        div_r = acc_q;
        div_q = wrk_q;
        div_t = '0;
        for (int i = 0; i < MD_STEP; i++) begin
            div_t = {div_r, div_q[XLEN-1]};
            div_q = {div_q[XLEN-2:0], 1'b0};
            if (div_t >= {1'b0, opd_q}) begin
                div_t    = div_t - {1'b0, opd_q};
                div_q[0] = 1'b1;
            end
            div_r = div_t[XLEN-1:0];
        end
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   res_hi, res_lo;
    always_comb begin
        prod   = {mul_h[XLEN-1:0], mul_l};
        prod_s = neg_res_q ? -prod : prod;
        if (state_q == S_MUL) begin
            res_hi = prod_s[2*XLEN-1:XLEN];
            res_lo = prod_s[XLEN-1:0];
        end else begin
            // Divide by zero leaves the dividend magnitude in the remainder, so HI comes out right.
            res_hi = neg_rem_q ? -div_r : div_r;
            res_lo = div0_q ? DIV0_LO : (neg_res_q ? -div_q : div_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            opd_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (start_md) begin
                cnt_q     <= CW'(CNT_INIT);
                acc_q     <= '0;
                wrk_q     <= is_mul_op ? b_mag : a_mag;
                opd_q     <= is_mul_op ? a_mag : b_mag;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                div0_q    <= (fwd_b == '0);
            end else if (md_busy) begin
                if (kill_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                    acc_q <= (state_q == S_MUL) ? mul_h[XLEN-1:0] : div_r;
                    wrk_q <= (state_q == S_MUL) ? mul_l : div_q;
                end
            end
            if (md_done) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (accept && md_op_i == 4'd7) begin
                hi_q <= fwd_a;
            end else if (accept && md_op_i == 4'd8) begin
                lo_q <= fwd_a;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule
